gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
Sequencer that drives a Gray-code count in bursts under a start/done handshake.
- Holds an N-bit binary state and outputs its registered Gray encoding.
- Steps it up or down for a programmed number of steps, one-shot or continuously reloading.
- Reports completion or abort to the requesting controller.
- Sits between a control FSM and logic consuming a single-bit-change Gray sequence (sync pointers, encoder stimulus).

Parameters:
N, 4, width of count, gray_out and len; all arithmetic modulo 2^N.

Ports:
clk  input  1  clock; all state updates on rising edge.
rstn  input  1  asynchronous active-low reset.
start  input  1  burst request; sampled only in IDLE.
len  input  N  steps per burst; latched on accepted start.
dir  input  1  0 = count up, 1 = count down; latched on accepted start.
mode  input  1  0 = one-shot, 1 = continuous reload; latched on accepted start.
clr  input  1  zero the count; honoured only in IDLE.
stop  input  1  abort request; honoured only in RUN.
done_ack  input  1  acknowledges done; honoured only in DONE.
gray_out  output  N  registered Gray code of internal binary count.
step_valid  output  1  high for the cycle after every step edge.
busy  output  1  high while state is RUN.
done  output  1  high while state is DONE.
aborted  output  1  high in DONE when the burst ended by stop.

Behaviour:
- Reset (rstn low, asynchronous, immediate):
  - state IDLE; binary count 0.
  - gray_out, step_valid, busy, done, aborted all 0.
  - latched len/dir/mode and remaining counter 0.
- Invariant: gray_out == bin ^ (bin >> 1) at all times; consecutive steps differ in exactly one bit, including across wrap 2^N-1 <-> 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - clr=1: bin <- 0, gray_out <- 0.
  - start=1 and len!=0: latch len/dir/mode; remaining <- len; go to RUN. clr has priority over start in the same cycle; start is still accepted and the burst begins from 0.
  - start with len==0: ignored, no state change.
  - stop and done_ack: ignored.
- RUN, one step per cycle:
  - bin <- bin ± 1 (wrap); gray_out updated on the same edge; step_valid=1 next cycle; remaining decrements.
  - Start accepted at edge k: steps on edges k+1 .. k+len.
  - Last step, mode=0: go to DONE on that same edge (done and final step_valid high together).
  - Last step, mode=1: remaining <- latched len; stay in RUN with no bubble.
  - stop=1: takes priority over stepping. No step that edge; count holds; step_valid=0; go to DONE with aborted=1.
  - start and clr: ignored.
- DONE:
  - done held high and count holds until done_ack=1; then IDLE, done=0, aborted=0 on that edge.
  - start in DONE (including the ack cycle): ignored.
- busy = (state == RUN); done = (state == DONE); both registered and decoded from the state register.
- Reset mid-burst: everything returns to reset values at once; no pending done.

Test Plan:
- Reset: drive rstn low asynchronously mid-cycle -> gray_out=0000, busy=0, done=0, step_valid=0 before the next edge.
- Up one-shot from 0: start, len=5, dir=0, mode=0 -> gray_out 0001, 0011, 0010, 0110, 0111 on consecutive edges; 5 step_valid cycles; done=1, aborted=0 with the 5th; done_ack -> IDLE, count stays 0111.
- Down wrap from 0: clr, then start, len=2, dir=1 -> bin 15, 14; gray_out 1000, 1001; done=1.
- Up wrap: from bin=14 (gray 1001), start, len=3, dir=0 -> gray_out 1000, 0000, 0001; every transition changes exactly one bit.
- Continuous plus stop: start, len=3, mode=1; stop asserted after the 7th step -> exactly 7 steps with no reload gap; DONE with aborted=1; gray_out frozen at the 7th value; start during DONE ignored.
- Ignore rules: start with len=0 in IDLE -> stays IDLE; start during RUN -> no change to the latched len; clr during RUN -> count unaffected.

Source files
------------

// File: rtl/gray_seq_ctrl_if.sv
// Handshake and Gray-count bundle between a requesting controller (master)
// and the Gray sequencer (slave).
interface gray_seq_ctrl_if #(parameter int N = 4);
  logic         start;
  logic [N-1:0] len;
  logic         dir;
  logic         mode;
  logic         clr;
  logic         stop;
  logic         done_ack;
  logic [N-1:0] gray_out;
  logic         step_valid;
  logic         busy;
  logic         done;
  logic         aborted;

  modport master (
    output start, len, dir, mode, clr, stop, done_ack,
    input  gray_out, step_valid, busy, done, aborted
  );

  modport slave (
    input  start, len, dir, mode, clr, stop, done_ack,
    output gray_out, step_valid, busy, done, aborted
  );
endinterface

// File: rtl/gray_seq_ctrl.sv
// Burst sequencer: steps an N-bit binary count up/down for a latched number
// of steps and presents its registered Gray encoding, with start/done handshake.
module gray_seq_ctrl #(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rstn,
  gray_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] bin, bin_nxt;
  logic [N-1:0] gray_q;
  logic [N-1:0] len_q, rem;
  logic         dir_q, mode_q;
  logic         step_valid_q, aborted_q;
  logic         accept, step, last;

  function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign accept  = (state == IDLE) && bus.start && (bus.len != '0);
  assign step    = (state == RUN) && !bus.stop;
  assign last    = (rem == N'(1));
  assign bin_nxt = dir_q ? (bin - N'(1)) : (bin + N'(1));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; stop wins over the final step
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN: begin
        if (bus.stop)            state_nxt = DONE;
        else if (last && !mode_q) state_nxt = DONE;
      end
      DONE:    if (bus.done_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state and datapath registers
  always_comb begin
    bus.busy       = (state == RUN);
    bus.done       = (state == DONE);
    bus.gray_out   = gray_q;
    bus.step_valid = step_valid_q;
    bus.aborted    = aborted_q;
  end

  // Count, burst bookkeeping and status flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bin          <= '0;
      gray_q       <= '0;
      len_q        <= '0;
      rem          <= '0;
      dir_q        <= 1'b0;
      mode_q       <= 1'b0;
      step_valid_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      step_valid_q <= step;
      case (state)
        IDLE: begin
          // clr and start may coincide: the burst then begins from zero
          if (bus.clr) begin
            bin    <= '0;
            gray_q <= '0;
          end
          if (accept) begin
            len_q  <= bus.len;
            dir_q  <= bus.dir;
            mode_q <= bus.mode;
            rem    <= bus.len;
          end
        end
        RUN: begin
          if (bus.stop) begin
            aborted_q <= 1'b1;
          end else begin
            bin    <= bin_nxt;
            gray_q <= to_gray(bin_nxt);
            rem    <= last ? len_q : (rem - N'(1));
          end
        end
        DONE: begin
          if (bus.done_ack) aborted_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Randomized and directed bench for gray_seq_ctrl against an integer burst model.
module tb_gray_seq_ctrl;
  localparam int N   = 4;
  localparam int MOD = 1 << N;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  gray_seq_ctrl_if #(.N(N)) bus ();
  gray_seq_ctrl #(.N(N)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 idle, 1 running, 2 finished
  int m_bin, m_phase, m_left, m_len, m_dir, m_mode, m_sv, m_ab;
  int prev_gray;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic drive(input bit st, input int ln, input bit d, input bit md,
                       input bit c, input bit sp, input bit ak);
    bus.start    = st;
    bus.len      = ln[N-1:0];
    bus.dir      = d;
    bus.mode     = md;
    bus.clr      = c;
    bus.stop     = sp;
    bus.done_ack = ak;
  endtask

  task automatic model_reset();
    m_bin = 0; m_phase = 0; m_left = 0; m_len = 0;
    m_dir = 0; m_mode = 0; m_sv = 0; m_ab = 0;
    prev_gray = 0;
  endtask

  // Called 1 time unit after a rising edge (or at start): pulses reset mid-cycle
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    check_eq("rst_gray", int'(bus.gray_out), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_done", int'(bus.done), 0);
    check_eq("rst_sv", int'(bus.step_valid), 0);
    check_eq("rst_abort", int'(bus.aborted), 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic cycle();
    int nb, nph, nl, nsv, nab;
    nb = m_bin; nph = m_phase; nl = m_left; nsv = 0; nab = m_ab;
    case (m_phase)
      0: begin
        if (bus.clr) nb = 0;
        if (bus.start && bus.len != 0) begin
          m_len = int'(bus.len); m_dir = int'(bus.dir); m_mode = int'(bus.mode);
          nl = m_len; nph = 1;
        end
      end
      1: begin
        if (bus.stop) begin
          nab = 1; nph = 2;
        end else begin
          nb  = m_dir ? (m_bin + MOD - 1) % MOD : (m_bin + 1) % MOD;
          nsv = 1;
          nl  = m_left - 1;
          if (nl == 0) begin
            if (m_mode != 0) nl = m_len;
            else             nph = 2;
          end
        end
      end
      default: begin
        if (bus.done_ack) begin nph = 0; nab = 0; end
      end
    endcase
    @(posedge clk);
    m_bin = nb; m_phase = nph; m_left = nl; m_sv = nsv; m_ab = nab;
    #1;
    check_eq("gray", int'(bus.gray_out), gray_of(m_bin));
    check_eq("step_valid", int'(bus.step_valid), m_sv);
    check_eq("busy", int'(bus.busy), int'(m_phase == 1));
    check_eq("done", int'(bus.done), int'(m_phase == 2));
    check_eq("aborted", int'(bus.aborted), m_ab);
    if (m_sv != 0)
      check_eq("one_bit", $countones(bus.gray_out ^ prev_gray[N-1:0]), 1);
    prev_gray = int'(bus.gray_out);
  endtask

  int up_exp[5]   = '{1, 3, 2, 6, 7};
  int dn_exp[2]   = '{8, 9};
  int wrap_exp[3] = '{8, 0, 1};

  initial begin
    int nsteps;
    int frozen;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    do_reset();

    // Up one-shot from 0
    drive(1, 5, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("up_seq", int'(bus.gray_out), up_exp[i]);
    end
    check_eq("up_done", int'(bus.done), 1);
    drive(0, 0, 0, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
    check_eq("up_hold", int'(bus.gray_out), 7);

    // Down wrap from 0, clr and start together
    drive(1, 2, 1, 0, 1, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check_eq("dn_seq", int'(bus.gray_out), dn_exp[i]);
    end
    check_eq("dn_done", int'(bus.done), 1);
    drive(0, 0, 0, 0, 0, 0, 1); cycle();

    // Up wrap from 14
    drive(1, 3, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("wrap_seq", int'(bus.gray_out), wrap_exp[i]);
    end
    drive(0, 0, 0, 0, 0, 0, 1); cycle();

    // Continuous reload, stop after the 7th step
    drive(1, 3, 0, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    nsteps = 0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      nsteps += int'(bus.step_valid);
    end
    check_eq("cont_steps", nsteps, 7);
    frozen = int'(bus.gray_out);
    drive(0, 0, 0, 0, 0, 1, 0); cycle();
    check_eq("stop_abort", int'(bus.aborted), 1);
    check_eq("stop_sv", int'(bus.step_valid), 0);
    check_eq("stop_frozen", int'(bus.gray_out), frozen);
    drive(1, 5, 0, 0, 0, 0, 0); cycle();
    check_eq("done_start_ign", int'(bus.done), 1);
    drive(1, 5, 0, 0, 0, 0, 1); cycle();
    check_eq("ack_start_ign", int'(bus.busy), 0);
    drive(0, 0, 0, 0, 0, 0, 0); cycle();

    // Ignore rules
    drive(1, 0, 0, 0, 0, 0, 0); cycle();
    check_eq("len0_ign", int'(bus.busy), 0);
    drive(1, 4, 1, 0, 0, 0, 0); cycle();
    drive(1, 1, 0, 1, 1, 0, 0); cycle(); cycle();
    drive(0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
    check_eq("run_ign_done", int'(bus.done), 1);
    drive(0, 0, 0, 0, 0, 0, 1); cycle();

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      drive($urandom_range(0, 9) < 3, int'($urandom_range(0, MOD - 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 3);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
